// File: rtl/axi_rr_packet_mux.sv
// Packet-granular round-robin merge of NUM_STREAMS AXI4-Stream inputs onto one registered output.
// Define AXI_RR_MUX_SELECT_EN to add the per-packet select stream consumed by the downstream demux.
module axi_rr_packet_mux #(
    parameter int unsigned  NUM_STREAMS   = 2,
    parameter int unsigned  AXI_DATA_BITS = 32,
    localparam int unsigned SEL_BITS      = $clog2(NUM_STREAMS),
    localparam int unsigned KEEP_BITS     = AXI_DATA_BITS / 8
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [NUM_STREAMS-1:0]                    in_tvalid,
    output logic [NUM_STREAMS-1:0]                    in_tready,
    input  logic [NUM_STREAMS-1:0][AXI_DATA_BITS-1:0] in_tdata,
    input  logic [NUM_STREAMS-1:0][KEEP_BITS-1:0]     in_tkeep,
    input  logic [NUM_STREAMS-1:0]                    in_tlast,
`ifdef AXI_RR_MUX_SELECT_EN
    output logic                                      select_valid,
    input  logic                                      select_ready,
    output logic [SEL_BITS-1:0]                       select_data,
`endif
    output logic                                      out_tvalid,
    input  logic                                      out_tready,
    output logic [AXI_DATA_BITS-1:0]                  out_tdata,
    output logic [KEEP_BITS-1:0]                      out_tkeep,
    output logic                                      out_tlast
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [SEL_BITS-1:0] ptr_q, ptr_d;
    logic [SEL_BITS-1:0] grant_q, grant_d;
    logic [SEL_BITS-1:0] cand_idx;
    logic                cand_found;
    int unsigned         scan_idx;
    logic                reg_free;
    logic                sel_free;
    logic                arb_fire;
    logic                beat_xfer;

    assign reg_free = !out_tvalid || out_tready;

`ifdef AXI_RR_MUX_SELECT_EN
    assign sel_free = !select_valid || select_ready;
`else
    assign sel_free = 1'b1;
`endif

    // First valid input at or after the rotating pointer
    always_comb begin
        cand_found = 1'b0;
        cand_idx   = '0;
        scan_idx   = 0;
        for (int unsigned k = 0; k < NUM_STREAMS; k++) begin
            scan_idx = (32'(ptr_q) + k) % NUM_STREAMS;
            if (!cand_found && in_tvalid[SEL_BITS'(scan_idx)]) begin
                cand_found = 1'b1;
                cand_idx   = SEL_BITS'(scan_idx);
            end
        end
    end

    // Next-state and handshake decode; tready never depends on any tvalid
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        arb_fire  = 1'b0;
        beat_xfer = 1'b0;
        in_tready = '0;
        case (state_q)
            IDLE: begin
                arb_fire = cand_found && sel_free;
                if (arb_fire) begin
                    grant_d = cand_idx;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                in_tready[grant_q] = reg_free;
                beat_xfer          = in_tvalid[grant_q] && reg_free;
                if (beat_xfer && in_tlast[grant_q]) begin
                    ptr_d   = (grant_q == SEL_BITS'(NUM_STREAMS - 1)) ? '0 : grant_q + SEL_BITS'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
        end
    end

    // One-entry output register; loads and drains in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            out_tvalid <= 1'b0;
            out_tdata  <= '0;
            out_tkeep  <= '0;
            out_tlast  <= 1'b0;
        end else if (beat_xfer) begin
            out_tvalid <= 1'b1;
            out_tdata  <= in_tdata[grant_q];
            out_tkeep  <= in_tkeep[grant_q];
            out_tlast  <= in_tlast[grant_q];
        end else if (out_tready) begin
            out_tvalid <= 1'b0;
        end
    end

`ifdef AXI_RR_MUX_SELECT_EN
    // Select register holds the granted index until the demux side takes it
    always_ff @(posedge clk) begin
        if (rst) begin
            select_valid <= 1'b0;
            select_data  <= '0;
        end else if (arb_fire) begin
            select_valid <= 1'b1;
            select_data  <= cand_idx;
        end else if (select_ready) begin
            select_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_axi_rr_packet_mux.sv
// Bench for axi_rr_packet_mux: directed scenarios plus randomized traffic against a packet-level RR model.
// Select-stream checks are active when AXI_RR_MUX_SELECT_EN is defined.
module tb_axi_rr_packet_mux;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned KW = DW / 8;
    localparam int unsigned SW = 2;
    localparam int          DEPTH = 256;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N-1:0]          in_tvalid;
    logic [N-1:0]          in_tready;
    logic [N-1:0][DW-1:0]  in_tdata;
    logic [N-1:0][KW-1:0]  in_tkeep;
    logic [N-1:0]          in_tlast;
    logic                  out_tvalid;
    logic                  out_tready;
    logic [DW-1:0]         out_tdata;
    logic [KW-1:0]         out_tkeep;
    logic                  out_tlast;
`ifdef AXI_RR_MUX_SELECT_EN
    logic                  select_valid;
    logic                  select_ready;
    logic [SW-1:0]         select_data;
    logic                  sel_hold_prev;
    logic [SW-1:0]         sel_prev;
`endif

    // Source beat storage and packet-level reference state
    beat_t       src_mem [N][DEPTH];
    int          src_head [N];
    int          src_tail [N];
    logic [N-1:0] mid_pkt;
    beat_t       exp_q [$];
    int          exp_sel_q [$];
    int          fire_cyc [$];
    int          model_ptr;
    int          n_checks;
    int          n_fail;

    always #5 clk = ~clk;

    axi_rr_packet_mux #(
        .NUM_STREAMS   (N),
        .AXI_DATA_BITS (DW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_tvalid    (in_tvalid),
        .in_tready    (in_tready),
        .in_tdata     (in_tdata),
        .in_tkeep     (in_tkeep),
        .in_tlast     (in_tlast),
`ifdef AXI_RR_MUX_SELECT_EN
        .select_valid (select_valid),
        .select_ready (select_ready),
        .select_data  (select_data),
`endif
        .out_tvalid   (out_tvalid),
        .out_tready   (out_tready),
        .out_tdata    (out_tdata),
        .out_tkeep    (out_tkeep),
        .out_tlast    (out_tlast)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add_packet(input int s, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = DW'($urandom);
            b.keep = KW'($urandom);
            b.last = (i == len - 1);
            src_mem[s][src_tail[s]] = b;
            src_tail[s]++;
        end
    endtask

    // Round-robin over whole packets: each arbitration picks the first source with a
    // pending packet starting at the pointer, then moves the pointer past it.
    task automatic build_expected();
        int  h [N];
        int  s;
        bit  found;
        bit  lst;
        for (int i = 0; i < N; i++) h[i] = src_head[i];
        while (1) begin
            found = 0;
            s = 0;
            for (int k = 0; k < N && !found; k++) begin
                s = (model_ptr + k) % N;
                if (h[s] != src_tail[s]) found = 1;
            end
            if (!found) break;
`ifdef AXI_RR_MUX_SELECT_EN
            exp_sel_q.push_back(s);
`endif
            do begin
                exp_q.push_back(src_mem[s][h[s]]);
                lst = src_mem[s][h[s]].last;
                h[s]++;
            end while (!lst);
            model_ptr = (s + 1) % N;
        end
    endtask

    // Sources stay valid whenever a packet is pending; gaps only occur mid-packet
    task automatic drive(input int c, input int mode, input int gap, input int stall);
        for (int i = 0; i < N; i++) begin
            if (src_head[i] != src_tail[i]) begin
                in_tdata[i]  = src_mem[i][src_head[i]].data;
                in_tkeep[i]  = src_mem[i][src_head[i]].keep;
                in_tlast[i]  = src_mem[i][src_head[i]].last;
                in_tvalid[i] = mid_pkt[i] ? (int'($urandom_range(99)) >= gap) : 1'b1;
            end else begin
                in_tdata[i]  = '0;
                in_tkeep[i]  = '0;
                in_tlast[i]  = 1'b0;
                in_tvalid[i] = 1'b0;
            end
        end
        case (mode)
            0:       out_tready = 1'b1;
            1:       out_tready = (c % 2 == 0);
            default: out_tready = ($urandom_range(3) != 0);
        endcase
`ifdef AXI_RR_MUX_SELECT_EN
        select_ready = (c < stall) ? 1'b0 : ((mode == 2) ? ($urandom_range(2) != 0) : 1'b1);
`else
        if (stall < 0) out_tready = 1'b0;
`endif
    endtask

    task automatic tick(input int c, input int mode, input int gap, input int stall,
                        output logic [N-1:0] acc);
        beat_t eb;
        drive(c, mode, gap, stall);
        #1;
        check("tready_onehot", 64'($countones(in_tready) <= 1), 64'd1);
        acc = in_tvalid & in_tready;
        if (out_tvalid && out_tready) begin
            check("out_beat_pending", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                eb = exp_q.pop_front();
                check("out_beat", 64'({out_tdata, out_tkeep, out_tlast}), 64'(eb));
            end
            fire_cyc.push_back(c);
        end
`ifdef AXI_RR_MUX_SELECT_EN
        if (sel_hold_prev) check("select_hold", 64'(select_data), 64'(sel_prev));
        if (select_valid && select_ready) begin
            check("select_pending", 64'(exp_sel_q.size() != 0), 64'd1);
            if (exp_sel_q.size() != 0) check("select_data", 64'(select_data), 64'(exp_sel_q.pop_front()));
        end
        sel_hold_prev = select_valid && !select_ready;
        sel_prev      = select_data;
`endif
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                mid_pkt[i] = !src_mem[i][src_head[i]].last;
                src_head[i]++;
            end
        end
    endtask

    task automatic run(input string name, input int mode, input int gap, input int stall,
                       input int stall_beats);
        int           c;
        int           acc_total;
        logic [N-1:0] acc;
        c = 0;
        acc_total = 0;
        fire_cyc.delete();
        build_expected();
        while (c < 3000 && (exp_q.size() != 0 || exp_sel_q.size() != 0)) begin
            tick(c, mode, gap, stall, acc);
            acc_total += $countones(acc);
`ifdef AXI_RR_MUX_SELECT_EN
            if (stall > 0 && c == stall - 1) begin
                check({name, "_stall_beats"}, 64'(acc_total), 64'(stall_beats));
                check({name, "_stall_valid"}, 64'(select_valid), 64'd1);
            end
`endif
            c++;
        end
        check({name, "_drained"}, 64'(exp_q.size() + exp_sel_q.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int           c;
        int           acc_total;
        int           np;
        logic [N-1:0] acc;

        n_checks  = 0;
        n_fail    = 0;
        model_ptr = 0;
        mid_pkt   = '0;
        for (int i = 0; i < N; i++) begin
            src_head[i] = 0;
            src_tail[i] = 0;
        end
`ifdef AXI_RR_MUX_SELECT_EN
        sel_hold_prev = 1'b0;
        sel_prev      = '0;
`endif
        rst = 1'b1;

        // Reset with every input valid, then 3-beat packets from all four streams
        for (int s = 0; s < N; s++) begin
            add_packet(s, 3);
            add_packet(s, 3);
        end
        drive(0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("rst_out_tvalid", 64'(out_tvalid), 64'd0);
            check("rst_in_tready", 64'(in_tready), 64'd0);
`ifdef AXI_RR_MUX_SELECT_EN
            check("rst_select_valid", 64'(select_valid), 64'd0);
`endif
        end
        @(negedge clk);
        rst = 1'b0;
        run("rr4", 0, 0, 0, 0);
        check("rr4_beats", 64'(fire_cyc.size()), 64'd24);
        for (int k = 1; k < fire_cyc.size(); k++)
            check("rr4_spacing", 64'(fire_cyc[k] - fire_cyc[k-1]), 64'((k % 3 == 0) ? 2 : 1));

        // 5-beat packet from stream 1 under toggling out_tready, stream 3 waiting
        add_packet(1, 5);
        add_packet(3, 2);
        run("toggle", 1, 0, 0, 0);
        check("toggle_beats", 64'(fire_cyc.size()), 64'd7);

        // Single-beat packets from stream 2 only: one beat every other cycle
        for (int p = 0; p < 6; p++) add_packet(2, 1);
        run("single", 0, 0, 0, 0);
        check("single_beats", 64'(fire_cyc.size()), 64'd6);
        for (int k = 1; k < fire_cyc.size(); k++)
            check("single_spacing", 64'(fire_cyc[k] - fire_cyc[k-1]), 64'd2);

        // Select held off for 10 cycles after the first grant
        add_packet(0, 2);
        add_packet(1, 2);
        run("selstall", 0, 0, 10, 2);

        // Reset while beat 2 of a 4-beat stream 3 packet is presented
        add_packet(3, 4);
        build_expected();
        c = 0;
        acc_total = 0;
        while (acc_total < 2 && c < 50) begin
            tick(c, 0, 0, 0, acc);
            acc_total += $countones(acc);
            c++;
        end
        check("midrst_reach", 64'(acc_total), 64'd2);
        rst = 1'b1;
        drive(c, 0, 0, 0);
        @(posedge clk);
        #1;
        check("midrst_out_tvalid", 64'(out_tvalid), 64'd0);
        check("midrst_in_tready", 64'(in_tready), 64'd0);
`ifdef AXI_RR_MUX_SELECT_EN
        check("midrst_select_valid", 64'(select_valid), 64'd0);
        sel_hold_prev = 1'b0;
`endif
        @(negedge clk);
        rst = 1'b0;
        src_head[3] = src_tail[3];
        mid_pkt     = '0;
        exp_q.delete();
        exp_sel_q.delete();
        model_ptr = 0;
        add_packet(0, 1);
        add_packet(2, 2);
        add_packet(3, 1);
        run("postrst", 0, 0, 0, 0);

        // Randomized traffic with mid-packet gaps and random backpressure
        for (int r = 0; r < 4; r++) begin
            for (int s = 0; s < N; s++) begin
                np = int'($urandom_range(3));
                for (int p = 0; p < np; p++) add_packet(s, 1 + int'($urandom_range(4)));
            end
            run("rand", 2, 30, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_rr_packet_mux.md
Name: axi_rr_packet_mux

Overview:
- Merges NUM_STREAMS AXI4S input streams into one AXI4S output stream.
- Arbitration is round-robin at packet granularity: a grant is held from the first beat of a packet until its tlast beat.
- Emits the granted source index per packet on a select stream, in the format the downstream AXI demultiplexer consumes, so a later stage can restore the original split.
- Sits directly upstream of the AXI demultiplexer in the stream fabric.

Parameters:
- NUM_STREAMS, 2, number of input streams; must be >= 2.
- SEL_BITS, $clog2(NUM_STREAMS), width of the select index (derived; not overridden).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- in[NUM_STREAMS]  AXI4S.s  AXI_DATA_BITS data, AXI_DATA_BITS/8 keep, last  input streams.
- out  AXI4S.m  AXI_DATA_BITS data, AXI_DATA_BITS/8 keep, last  merged output stream.
- select  ready_valid_i.m  SEL_BITS  granted source index, one transfer per packet.

Behaviour:
- Reset values: out.tvalid=0; out.tdata/tkeep/tlast=0; select.valid=0; select.data=0; all in[i].tready=0; state=IDLE; rr pointer=0; grant index=0.
- Output register: one-entry register on out.
  - reg_free = !out.tvalid || out.tready.
  - Loads when an input beat is accepted; otherwise clears tvalid when out.tready is high.
  - A beat accepted in cycle N is presented on out in cycle N+1.
  - Full throughput with out.tready held high.
- Select register: one entry, holds select.valid and data until select.ready. sel_free = !select.valid || select.ready.
- State IDLE:
  - All in[i].tready=0.
  - Candidate = first i in (ptr, ptr+1, ..., ptr+NUM_STREAMS-1) mod NUM_STREAMS with in[i].tvalid=1.
  - If a candidate exists and sel_free: load select.data=candidate, set select.valid=1, set grant=candidate, go to GRANT.
  - Otherwise remain in IDLE.
  - Arbitration costs one bubble cycle per packet.
- State GRANT:
  - in[grant].tready = reg_free; all other in[i].tready=0.
  - A beat transfers when in[grant].tvalid && reg_free.
  - On a transferred beat with tlast=1: ptr = (grant+1) mod NUM_STREAMS (wraps to 0 when grant=NUM_STREAMS-1), go to IDLE.
  - Non-granted inputs are never accepted mid-packet, even if valid.
- No combinational path from any in[i].tvalid to any in[j].tready. in[grant].tready depends only on registered state and out.tready.
- Data, keep and last are passed through unmodified; no width conversion.
- Single-beat packet (first beat has tlast=1): IDLE -> GRANT -> IDLE, two cycles per packet.
- Select backpressure: with select.ready=0 and select.valid=1, IDLE stalls; the packet already in GRANT continues unaffected.
- Simultaneous events:
  - Output register loads and drains in the same cycle when out.tready=1 and a beat is accepted.
  - Select loads and drains in the same cycle when select.ready=1 and arbitration fires.
- Reset mid-packet: grant dropped, registers cleared, ptr=0. The remainder of the interrupted packet is owned by upstream; the block does not resynchronise on tlast.

Optional Feature:
- Macro: AXI_RR_MUX_SELECT_EN.
- Defined: the select port exists and arbitration is gated by sel_free, as specified above.
- Undefined: the select port and select register are removed; arbitration ignores sel_free; all other behaviour is identical.

Test Plan:
- Reset: assert rst for 3 cycles with all inputs valid -> out.tvalid=0, select.valid=0, all tready=0 throughout; first grant after release goes to stream 0.
- NUM_STREAMS=4, all inputs continuously valid, packets of 3 beats, out.tready=1, select.ready=1 -> select sequence 0,1,2,3,0; each packet's 3 beats contiguous on out; 4 cycles per packet.
- NUM_STREAMS=4, only stream 2 valid, single-beat packets -> select always 2; one beat every 2 cycles; payloads bit-exact.
- out.tready toggled 1,0,1,0 during a 5-beat packet from stream 1 while stream 3 is valid -> no beat lost or duplicated; stream 3 not granted until stream 1's tlast is accepted; tkeep/tlast preserved.
- select.ready=0 for 10 cycles after the first grant -> first packet completes; second arbitration waits until select.ready=1; select.data holds stable while stalled.
- rst asserted in the middle of beat 2 of a 4-beat packet from stream 3 -> next cycle out.tvalid=0 and state=IDLE; after release, arbitration starts from stream 0.
